dec_chain_ctrl: RTL
===================

Name: dec_chain_ctrl

Overview:
Sequencer and configurator for the receive decimation chain: CIC, then up to two cascaded short halfband decimators.
- Holds the decimation configuration written over the settings bus and drives the CIC rate and per-halfband bypass controls.
- Gates the chain's run enable.
- Discards the filter-transient output samples after each start, so downstream only sees settled data.

Parameters:
BASE, 0, settings-bus address of the config register.
FLUSH_SAMPS, 8, number of decimated output strobes discarded after each start (0..255; 0 disables flushing).

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous reset, active-low.
set_stb  in  1  settings-bus write strobe.
set_addr  in  8  settings-bus address.
set_data  in  32  settings-bus data.
run  in  1  stream enable from the receive control.
stb_dec  in  1  final output strobe of the decimation chain.
cic_rate  out  8  active CIC decimation rate (1..255).
hb1_bypass  out  1  bypass for the first halfband.
hb2_bypass  out  1  bypass for the second halfband.
chain_run  out  1  run enable to the CIC and halfbands.
stb_out  out  1  gated output strobe to downstream.
dec_total  out  10  active total decimation, equal to cic_rate << (number of enabled halfbands).
samp_count  out  32  stb_out pulses since last start; saturates at 0xFFFF_FFFF.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Config word at BASE:
  - set_data[7:0] = cic_rate; a value of 0 is stored as 1.
  - set_data[8] = hb1_en.
  - set_data[9] = hb2_en; honoured only when hb1_en=1, otherwise forced to 0.
  - Upper bits are ignored. Writes to other addresses are ignored.
- Pending register:
  - Every matching write updates the pending config, in any state.
  - Reset value: rate=1, hb1_en=0, hb2_en=0.
- Active config (drives cic_rate, hb1_bypass=~hb1_en, hb2_bypass=~hb2_en, dec_total):
  - Loaded only on the IDLE->START edge.
  - Loaded from set_data if a matching write occurs in that same cycle, otherwise from pending.
  - Active config never changes outside this edge.
- Reset (rst_n=0 sampled at a clock edge):
  - state=IDLE.
  - Outputs after reset: cic_rate=1, hb1_bypass=1, hb2_bypass=1, chain_run=0, stb_out=0, dec_total=1, samp_count=0, busy=0.
- All outputs are registered.
- States: IDLE, START, FLUSH, RUN.
- IDLE:
  - chain_run=0.
  - run=1 -> START.
- START (exactly one cycle):
  - samp_count cleared; flush counter cleared.
  - Next state: FLUSH if FLUSH_SAMPS>0, else RUN.
  - chain_run becomes 1 on entry to FLUSH/RUN, i.e. 2 cycles after the cycle in which run was first sampled high.
- FLUSH:
  - Each stb_dec increments the flush counter; stb_out stays 0.
  - The stb_dec that brings the count to FLUSH_SAMPS -> RUN. That strobe itself is discarded.
- RUN:
  - stb_out <= stb_dec (1-cycle latency).
  - Each stb_out pulse increments samp_count.
- run=0 in any non-IDLE state:
  - Next state IDLE; chain_run=0 and stb_out=0 from the next cycle.
  - A stb_dec in that same cycle is dropped.
- Reset mid-operation overrides everything, including a concurrent write.
- run held high continuously: no restart. A new config takes effect only after run drops and rises again.
- Back-to-back run toggles (1,0,1): each rise passes through a full START/flush sequence.

Decomposition:
- Package dec_chain_pkg:
  - State enum (IDLE, START, FLUSH, RUN; 2 bits).
  - Config field bit positions.
  - Default rate constant.
  - Saturation max for samp_count.
- One sub-module, dec_cfg_reg:
  - Settings-bus address decode, rate-0 fix-up and hb2 masking.
  - Holds the pending config; outputs the forwarded next-pending value for the IDLE->START load.

Test Plan:
1. Reset defaults: hold rst_n=0 for 3 clocks, release -> cic_rate=1, both bypass=1, dec_total=1, chain_run=0, busy=0.
2. Config + start: write 0x3_10 (rate 16, both halfbands) in IDLE, raise run -> at START+1 cic_rate=16, bypass=0/0, dec_total=64, chain_run=1.
3. Flush: FLUSH_SAMPS=8, run high, 12 stb_dec pulses -> first 8 suppressed, then 4 stb_out pulses each 1 cycle after stb_dec; samp_count=4.
4. Write while running: write rate 0 with hb2_en only -> active unchanged. After run 1->0->1: cic_rate=1, hb1_bypass=1, hb2_bypass=1 (rate fixed up, hb2 masked).
5. Stop: run drops in the same cycle as a stb_dec in RUN -> no stb_out for it; IDLE next cycle; chain_run=0.
6. Edge cases:
   - Write coincident with run rise is applied in that start.
   - rst_n=0 during FLUSH -> IDLE, outputs at reset values.
   - FLUSH_SAMPS=0 -> first stb_dec passes through.
   - samp_count preset near max saturates at 0xFFFF_FFFF.

Source files
------------

// File: rtl/dec_chain_pkg.sv
// Shared types and constants for the receive decimation chain controller.
// Config layout, state encoding, reset defaults and the total-decimation helper.
package dec_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int CFG_RATE_LSB = 0;
    localparam int CFG_RATE_MSB = 7;
    localparam int CFG_HB1_BIT  = 8;
    localparam int CFG_HB2_BIT  = 9;

    localparam logic [7:0]  DEFAULT_RATE = 8'd1;
    localparam logic [31:0] SAMP_MAX     = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [7:0] rate;
        logic       hb1_en;
        logic       hb2_en;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{rate: DEFAULT_RATE, hb1_en: 1'b0, hb2_en: 1'b0};

    // hb2 sits behind hb1, so it is only meaningful when hb1 is enabled
    function automatic cfg_t cfg_decode(input logic [9:0] d);
        cfg_t c;
        c.rate   = (d[CFG_RATE_MSB:CFG_RATE_LSB] == 8'd0) ? DEFAULT_RATE
                                                          : d[CFG_RATE_MSB:CFG_RATE_LSB];
        c.hb1_en = d[CFG_HB1_BIT];
        c.hb2_en = d[CFG_HB2_BIT] & d[CFG_HB1_BIT];
        return c;
    endfunction

    function automatic logic [9:0] total_dec(input cfg_t c);
        logic [1:0] n_hb;
        n_hb = {1'b0, c.hb1_en} + {1'b0, c.hb2_en};
        return {2'b00, c.rate} << n_hb;
    endfunction

endpackage

// File: rtl/dec_cfg_reg.sv
// Settings-bus config register: address decode, rate-0 fix-up, hb2 masking.
// Latency: pending updates one cycle after a write; next_cfg forwards the write combinationally.
// Backpressure: none, every matching write is accepted.
module dec_cfg_reg
    import dec_chain_pkg::*;
#(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    output cfg_t        next_cfg
);

    cfg_t pend_cfg;
    logic hit;
    logic unused_hi;

    assign hit       = set_stb && (set_addr == BASE);
    assign unused_hi = ^set_data[31:10];
    assign next_cfg  = hit ? cfg_decode(set_data[9:0]) : pend_cfg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_cfg <= CFG_RESET;
        end else begin
            pend_cfg <= next_cfg;
        end
    end

endmodule

// File: rtl/dec_chain_ctrl.sv
// Decimation chain sequencer: latches config at start, flushes transient outputs, gates strobes.
// Latency: chain_run 2 cycles after run rises; stb_out follows stb_dec by 1 cycle in RUN.
// Backpressure: none; run=0 aborts at once and drops any coincident strobe.
module dec_chain_ctrl
    import dec_chain_pkg::*;
#(
    parameter logic [7:0] BASE        = 8'd0,
    parameter int          FLUSH_SAMPS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        run,
    input  logic        stb_dec,
    output logic [7:0]  cic_rate,
    output logic        hb1_bypass,
    output logic        hb2_bypass,
    output logic        chain_run,
    output logic        stb_out,
    output logic [9:0]  dec_total,
    output logic [31:0] samp_count,
    output logic        busy
);

    localparam logic [7:0] FLUSH_LIM = 8'(FLUSH_SAMPS);

    state_t     state;
    logic [7:0] flush_cnt;
    cfg_t       next_cfg;

    dec_cfg_reg #(.BASE(BASE)) u_cfg (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .next_cfg (next_cfg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            flush_cnt  <= 8'd0;
            cic_rate   <= DEFAULT_RATE;
            hb1_bypass <= 1'b1;
            hb2_bypass <= 1'b1;
            chain_run  <= 1'b0;
            stb_out    <= 1'b0;
            dec_total  <= 10'd1;
            samp_count <= 32'd0;
            busy       <= 1'b0;
        end else begin
            stb_out <= 1'b0;
            case (state)
                IDLE: begin
                    chain_run <= 1'b0;
                    if (run) begin
                        state      <= START;
                        busy       <= 1'b1;
                        cic_rate   <= next_cfg.rate;
                        hb1_bypass <= ~next_cfg.hb1_en;
                        hb2_bypass <= ~next_cfg.hb2_en;
                        dec_total  <= total_dec(next_cfg);
                    end
                end
                START: begin
                    samp_count <= 32'd0;
                    flush_cnt  <= 8'd0;
                    if (!run) begin
                        state     <= IDLE;
                        chain_run <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state     <= (FLUSH_LIM != 8'd0) ? FLUSH : RUN;
                        chain_run <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (!run) begin
                        state     <= IDLE;
                        chain_run <= 1'b0;
                        busy      <= 1'b0;
                    end else if (stb_dec) begin
                        // the strobe that completes the flush is itself discarded
                        flush_cnt <= flush_cnt + 8'd1;
                        if (flush_cnt + 8'd1 == FLUSH_LIM) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!run) begin
                        state     <= IDLE;
                        chain_run <= 1'b0;
                        busy      <= 1'b0;
                    end else if (stb_dec) begin
                        stb_out <= 1'b1;
                        if (samp_count != SAMP_MAX) begin
                            samp_count <= samp_count + 32'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
